// File: rtl/turf_udp_timeserver_v2.sv
// +---------------------------------------------------------------------------------------+
// | turf_udp_timeserver_v2 -- queues UDP time requests and replies with the PPS-aligned   |
// | second. Rev 1.0. Define TURF_TIMESERVER_SUBSEC_EN to append the subsecond count.      |
// +---------------------------------------------------------------------------------------+
`default_nettype none
module turf_udp_timeserver_v2 #(
  parameter int    FIFO_DEPTH = 16,
  parameter string MODE       = "PPS"
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [63:0] s_udphdr_tdata,
  input  logic        s_udphdr_tvalid,
  output logic        s_udphdr_tready,
  input  logic [63:0] s_udpdata_tdata,
  input  logic [7:0]  s_udpdata_tkeep,
  input  logic        s_udpdata_tlast,
  input  logic        s_udpdata_tvalid,
  output logic        s_udpdata_tready,
  output logic [63:0] m_udphdr_tdata,
  output logic        m_udphdr_tvalid,
  input  logic        m_udphdr_tready,
  output logic [63:0] m_udpdata_tdata,
  output logic [7:0]  m_udpdata_tkeep,
  output logic        m_udpdata_tlast,
  output logic        m_udpdata_tvalid,
  input  logic        m_udpdata_tready,
  input  logic        pps_i,
  input  logic [31:0] cur_sec_i,
  output logic [15:0] drop_count_o
);
  localparam bit IMMEDIATE = (MODE == "IMMEDIATE");
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
`ifdef TURF_TIMESERVER_SUBSEC_EN
  localparam logic [15:0] REPLY_LEN  = 16'd8;
  localparam logic [7:0]  REPLY_KEEP = 8'hFF;
`else
  localparam logic [15:0] REPLY_LEN  = 16'd4;
  localparam logic [7:0]  REPLY_KEEP = 8'h0F;
`endif

  typedef enum logic [1:0] {IDLE, SEND_HDR, SEND_DATA} state_t;

  // Queue entry layout: {epoch tag, ip[31:0], port[15:0]}
  logic [48:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [48:0]      head;
  logic             empty, full, push, pop, drop, toggle, enq_tag, more;
  logic [31:0]      subsec_field;

  state_t state;
  logic   epoch, pps_pending, serve_tag;

  logic unused_inputs;
  assign unused_inputs = ^{s_udphdr_tdata[15:0], s_udpdata_tdata, s_udpdata_tkeep,
                           s_udpdata_tlast, s_udpdata_tvalid};

  function automatic logic [31:0] byte_swap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  assign s_udphdr_tready  = 1'b1;
  assign s_udpdata_tready = 1'b1;
  assign m_udpdata_tkeep  = REPLY_KEEP;
  assign m_udpdata_tlast  = 1'b1;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign head    = mem[rd_ptr];
  assign pop     = m_udphdr_tvalid && m_udphdr_tready;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign push    = s_udphdr_tvalid && (!full || pop);
  assign drop    = s_udphdr_tvalid && full && !pop;
  assign toggle  = !IMMEDIATE && (state == IDLE) && (pps_i || pps_pending) && !empty;
  assign enq_tag = toggle ? ~epoch : epoch;
  assign more    = !empty && (IMMEDIATE || (head[48] == serve_tag));

`ifdef TURF_TIMESERVER_SUBSEC_EN
  logic [31:0] subsec;
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)
      subsec <= '0;
    else if (pps_i)
      subsec <= '0;
    else if (subsec != 32'hFFFF_FFFF)
      subsec <= subsec + 32'd1;
  end
  assign subsec_field = subsec;
`else
  assign subsec_field = '0;
`endif

  always_ff @(posedge aclk) begin
    if (push)
      mem[wr_ptr] <= {enq_tag, s_udphdr_tdata[63:16]};
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      drop_count_o <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop && (drop_count_o != 16'hFFFF))
        drop_count_o <= drop_count_o + 16'd1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state            <= IDLE;
      epoch            <= 1'b0;
      pps_pending      <= 1'b0;
      serve_tag        <= 1'b0;
      m_udphdr_tvalid  <= 1'b0;
      m_udphdr_tdata   <= '0;
      m_udpdata_tvalid <= 1'b0;
      m_udpdata_tdata  <= '0;
    end else begin
      if (!IMMEDIATE && pps_i)
        pps_pending <= 1'b1;
      case (state)
        IDLE: begin
          if (IMMEDIATE) begin
            if (!empty) begin
              state           <= SEND_HDR;
              m_udphdr_tvalid <= 1'b1;
              m_udphdr_tdata  <= {head[47:0], REPLY_LEN};
            end
          end else if (pps_i || pps_pending) begin
            pps_pending <= 1'b0;
            if (!empty) begin
              epoch           <= ~epoch;
              serve_tag       <= epoch;
              state           <= SEND_HDR;
              m_udphdr_tvalid <= 1'b1;
              m_udphdr_tdata  <= {head[47:0], REPLY_LEN};
            end
          end
        end
        SEND_HDR: begin
          if (m_udphdr_tready) begin
            m_udphdr_tvalid  <= 1'b0;
            m_udpdata_tvalid <= 1'b1;
            m_udpdata_tdata  <= {byte_swap(subsec_field), byte_swap(cur_sec_i)};
            state            <= SEND_DATA;
          end
        end
        SEND_DATA: begin
          if (m_udpdata_tready) begin
            m_udpdata_tvalid <= 1'b0;
            if (more) begin
              state           <= SEND_HDR;
              m_udphdr_tvalid <= 1'b1;
              m_udphdr_tdata  <= {head[47:0], REPLY_LEN};
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_turf_udp_timeserver_v2.sv
// Bench for turf_udp_timeserver_v2: a PPS-mode instance (depth 4) and an IMMEDIATE instance
// share the request stream; replies are compared against a queue-level model of the time server.
`default_nettype none
module tb_turf_udp_timeserver_v2;
  localparam int DEPTH_P = 4;
`ifdef TURF_TIMESERVER_SUBSEC_EN
  localparam logic [15:0] LEN   = 16'd8;
  localparam logic [7:0]  KEEP  = 8'hFF;
  localparam logic [63:0] DMASK = 64'h0000_0000_FFFF_FFFF;
`else
  localparam logic [15:0] LEN   = 16'd4;
  localparam logic [7:0]  KEEP  = 8'h0F;
  localparam logic [63:0] DMASK = 64'hFFFF_FFFF_FFFF_FFFF;
`endif

  logic aclk = 1'b0, areset = 1'b1;
  always #5 aclk = ~aclk;

  logic [63:0] req_tdata = '0;
  logic        req_tvalid = 1'b0;
  logic [63:0] pay_tdata = '0;
  logic        pps = 1'b0;
  logic [31:0] cur_sec = '0;

  logic p_hdr_rdy = 1'b1, p_dat_rdy = 1'b1, i_hdr_rdy = 1'b1, i_dat_rdy = 1'b1;
  logic [63:0] p_hdr_data, p_dat_data, i_hdr_data, i_dat_data;
  logic        p_hdr_vld, p_dat_vld, i_hdr_vld, i_dat_vld, p_last, i_last;
  logic        p_sh_rdy, p_sd_rdy, i_sh_rdy, i_sd_rdy;
  logic [7:0]  p_keep, i_keep;
  logic [15:0] p_drops, i_drops;

  turf_udp_timeserver_v2 #(.FIFO_DEPTH(DEPTH_P), .MODE("PPS")) dut_p (
    .aclk(aclk), .areset(areset),
    .s_udphdr_tdata(req_tdata), .s_udphdr_tvalid(req_tvalid), .s_udphdr_tready(p_sh_rdy),
    .s_udpdata_tdata(pay_tdata), .s_udpdata_tkeep(8'hFF), .s_udpdata_tlast(1'b1),
    .s_udpdata_tvalid(req_tvalid), .s_udpdata_tready(p_sd_rdy),
    .m_udphdr_tdata(p_hdr_data), .m_udphdr_tvalid(p_hdr_vld), .m_udphdr_tready(p_hdr_rdy),
    .m_udpdata_tdata(p_dat_data), .m_udpdata_tkeep(p_keep), .m_udpdata_tlast(p_last),
    .m_udpdata_tvalid(p_dat_vld), .m_udpdata_tready(p_dat_rdy),
    .pps_i(pps), .cur_sec_i(cur_sec), .drop_count_o(p_drops));

  turf_udp_timeserver_v2 #(.FIFO_DEPTH(16), .MODE("IMMEDIATE")) dut_i (
    .aclk(aclk), .areset(areset),
    .s_udphdr_tdata(req_tdata), .s_udphdr_tvalid(req_tvalid), .s_udphdr_tready(i_sh_rdy),
    .s_udpdata_tdata(pay_tdata), .s_udpdata_tkeep(8'hFF), .s_udpdata_tlast(1'b1),
    .s_udpdata_tvalid(req_tvalid), .s_udpdata_tready(i_sd_rdy),
    .m_udphdr_tdata(i_hdr_data), .m_udphdr_tvalid(i_hdr_vld), .m_udphdr_tready(i_hdr_rdy),
    .m_udpdata_tdata(i_dat_data), .m_udpdata_tkeep(i_keep), .m_udpdata_tlast(i_last),
    .m_udpdata_tvalid(i_dat_vld), .m_udpdata_tready(i_dat_rdy),
    .pps_i(pps), .cur_sec_i(cur_sec), .drop_count_o(i_drops));

  int errs = 0, checks = 0;

  task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Seconds are sent most-significant byte first, i.e. in the lowest byte lane.
  function automatic logic [31:0] be(input logic [31:0] v);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = v[8*(3-b) +: 8];
    return r;
  endfunction

  typedef struct { logic [31:0] ip; logic [15:0] port; } req_t;
  req_t        model_q[$];
  int          model_drops = 0;
  logic [63:0] exp_p_hdr[$], exp_p_dat[$], exp_i_hdr[$], exp_i_dat[$];
  logic [63:0] got_p_hdr[$], got_p_dat[$], got_i_hdr[$], got_i_dat[$];

  always @(negedge aclk) begin
    if (!areset) begin
      if (p_hdr_vld && p_hdr_rdy) got_p_hdr.push_back(p_hdr_data);
      if (i_hdr_vld && i_hdr_rdy) got_i_hdr.push_back(i_hdr_data);
      if (p_dat_vld && p_dat_rdy) begin
        got_p_dat.push_back(p_dat_data);
        check64("p keep/last", {p_keep, 7'd0, p_last}, {KEEP, 8'd1});
      end
      if (i_dat_vld && i_dat_rdy) begin
        got_i_dat.push_back(i_dat_data);
        check64("i keep/last", {i_keep, 7'd0, i_last}, {KEEP, 8'd1});
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  function automatic void model_push(input logic [31:0] ip, input logic [15:0] port,
                                     input logic [31:0] sec_i);
    req_t r;
    r.ip = ip; r.port = port;
    if (model_q.size() < DEPTH_P) model_q.push_back(r);
    else model_drops++;
    exp_i_hdr.push_back({ip, port, LEN});
    exp_i_dat.push_back({32'h0, be(sec_i)});
  endfunction

  task automatic send_req(input logic [31:0] ip, input logic [15:0] port);
    req_tdata = {ip, port, 16'($urandom)};
    pay_tdata = {$urandom, $urandom};
    req_tvalid = 1'b1;
    model_push(ip, port, cur_sec);
    @(posedge aclk); #1;
    req_tvalid = 1'b0;
  endtask

  // Every request queued before this pulse is answered with new_sec; an optional request
  // in the same cycle belongs to the following second.
  task automatic do_pps(input logic [31:0] new_sec, input bit with_req,
                        input logic [31:0] ip, input logic [15:0] port);
    pps = 1'b1;
    foreach (model_q[k]) begin
      exp_p_hdr.push_back({model_q[k].ip, model_q[k].port, LEN});
      exp_p_dat.push_back({32'h0, be(new_sec)});
    end
    model_q.delete();
    if (with_req) begin
      req_tdata = {ip, port, 16'h0};
      req_tvalid = 1'b1;
      model_push(ip, port, new_sec);
    end
    @(posedge aclk); #1;
    pps = 1'b0;
    req_tvalid = 1'b0;
    cur_sec = new_sec;
  endtask

  task automatic wait_replies();
    int n = 0;
    while ((got_p_dat.size() < exp_p_dat.size() || got_i_dat.size() < exp_i_dat.size())
           && n < 400) begin
      cycles(1);
      n++;
    end
    cycles(6);
  endtask

  task automatic check_all(input string name);
    wait_replies();
    check64({name, " p count"}, 64'(got_p_dat.size() + got_p_hdr.size()),
            64'(exp_p_dat.size() + exp_p_hdr.size()));
    check64({name, " i count"}, 64'(got_i_dat.size() + got_i_hdr.size()),
            64'(exp_i_dat.size() + exp_i_hdr.size()));
    while (got_p_hdr.size() > 0 && exp_p_hdr.size() > 0)
      check64({name, " p hdr"}, got_p_hdr.pop_front(), exp_p_hdr.pop_front());
    while (got_p_dat.size() > 0 && exp_p_dat.size() > 0)
      check64({name, " p data"}, got_p_dat.pop_front() & DMASK, exp_p_dat.pop_front());
    while (got_i_hdr.size() > 0 && exp_i_hdr.size() > 0)
      check64({name, " i hdr"}, got_i_hdr.pop_front(), exp_i_hdr.pop_front());
    while (got_i_dat.size() > 0 && exp_i_dat.size() > 0)
      check64({name, " i data"}, got_i_dat.pop_front() & DMASK, exp_i_dat.pop_front());
    got_p_hdr.delete(); got_p_dat.delete(); got_i_hdr.delete(); got_i_dat.delete();
    exp_p_hdr.delete(); exp_p_dat.delete(); exp_i_hdr.delete(); exp_i_dat.delete();
  endtask

  typedef struct {
    logic [31:0] ip; logic [15:0] port; logic [31:0] sec;
    logic [63:0] exp_hdr; logic [63:0] exp_dat;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] ip, sec;
    logic [15:0] port;
    logic [63:0] held, g;

    vecs[0] = '{32'h0A000001, 16'h1234, 32'h0000_0100, {32'h0A000001, 16'h1234, LEN},
                64'h0000_0000_0001_0000};
    vecs[1] = '{32'hFFFFFFFF, 16'hFFFF, 32'h1234_5678, {32'hFFFFFFFF, 16'hFFFF, LEN},
                64'h0000_0000_7856_3412};
    vecs[2] = '{32'hC0A80101, 16'h0050, 32'h0000_0000, {32'hC0A80101, 16'h0050, LEN},
                64'h0};
    for (int k = 3; k < 8; k++) begin
      vecs[k].ip = $urandom; vecs[k].port = 16'($urandom); vecs[k].sec = $urandom;
      vecs[k].exp_hdr = {vecs[k].ip, vecs[k].port, LEN};
      vecs[k].exp_dat = {32'h0, be(vecs[k].sec)};
    end

    cycles(3);
    areset = 1'b0;
    cycles(2);
    check64("reset valids", {p_hdr_vld, p_dat_vld, i_hdr_vld, i_dat_vld}, 64'h0);
    check64("reset drops", {p_drops, i_drops}, 64'h0);
    check64("treadys", {p_sh_rdy, p_sd_rdy, i_sh_rdy, i_sd_rdy}, 64'hF);
    cycles(10);
    check64("no reply without request", 64'(got_p_hdr.size() + got_i_hdr.size()), 64'h0);

    for (int k = 0; k < 8; k++) begin
      send_req(vecs[k].ip, vecs[k].port);
      cycles(10);
      do_pps(vecs[k].sec, 1'b0, '0, '0);
      wait_replies();
      g = (got_p_hdr.size() > 0) ? got_p_hdr[0] : 'x;
      check64($sformatf("vec%0d hdr", k), g, vecs[k].exp_hdr);
      g = (got_p_dat.size() > 0) ? got_p_dat[0] : 'x;
      check64($sformatf("vec%0d data", k), g & DMASK, vecs[k].exp_dat);
      check_all($sformatf("vec%0d", k));
    end

    // Three requests answered at one second, two more at the next
    for (int k = 0; k < 3; k++) send_req(32'h0A000010 + k, 16'(100 + k));
    cycles(10);
    do_pps(32'h200, 1'b0, '0, '0);
    check_all("three then");
    for (int k = 0; k < 2; k++) send_req(32'h0A000020 + k, 16'(200 + k));
    cycles(10);
    do_pps(32'h201, 1'b0, '0, '0);
    check_all("two after");

    // Request coincident with the pulse belongs to the next second
    send_req(32'h0B000001, 16'h0001);
    cycles(10);
    do_pps(32'h300, 1'b1, 32'h0B000002, 16'h0002);
    check_all("same-cycle pps");
    do_pps(32'h301, 1'b0, '0, '0);
    check_all("next second");

    // Overflow of the depth-4 queue
    for (int k = 0; k < 6; k++) send_req(32'h0C000000 + k, 16'(k));
    cycles(2);
    check64("drop count", {p_drops, i_drops}, {16'(model_drops), 16'd0});
    cycles(10);
    do_pps(32'h400, 1'b0, '0, '0);
    check_all("overflow order");

    for (int r = 0; r < 5; r++) begin
      int n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        send_req($urandom, 16'($urandom));
        cycles($urandom_range(0, 3));
      end
      cycles(2);
      check64($sformatf("rand%0d drops", r), {48'h0, p_drops}, 64'(model_drops));
      cycles(10);
      do_pps(cur_sec + 32'd1, 1'b0, '0, '0);
      check_all($sformatf("rand%0d", r));
    end

    // IMMEDIATE reply held under backpressure
    i_hdr_rdy = 1'b0;
    ip = 32'h0D0D0D0D; port = 16'hBEEF;
    send_req(ip, port);
    cycles(3);
    held = {ip, port, LEN};
    for (int k = 0; k < 10; k++) begin
      check64($sformatf("hold%0d", k), {i_hdr_vld, i_hdr_data}, {1'b1, held});
      cycles(1);
    end
    i_hdr_rdy = 1'b1;
    do_pps(cur_sec + 32'd1, 1'b0, '0, '0);
    check_all("backpressure");

`ifdef TURF_TIMESERVER_SUBSEC_EN
    send_req(32'h0E000001, 16'h0E01);
    cycles(10);
    p_hdr_rdy = 1'b0;
    do_pps(cur_sec + 32'd1, 1'b0, '0, '0);
    cycles(100);
    p_hdr_rdy = 1'b1;
    wait_replies();
    g = (got_p_dat.size() > 0) ? got_p_dat[0] : 'x;
    sec = be(g[63:32]);
    check64("subsec window", 64'(sec >= 32'd99 && sec <= 32'd101), 64'd1);
    check_all("subsec");
`endif

    // Reset while a reply payload is pending
    for (int k = 0; k < 3; k++) send_req(32'h0F000000 + k, 16'(k));
    cycles(10);
    p_dat_rdy = 1'b0;
    do_pps(cur_sec + 32'd1, 1'b0, '0, '0);
    cycles(5);
    check64("data pending", {63'h0, p_dat_vld}, 64'd1);
    #2 areset = 1'b1;
    @(negedge aclk);
    check64("reset drops valid", {p_hdr_vld, p_dat_vld}, 64'h0);
    @(posedge aclk); #1;
    areset = 1'b0;
    model_q.delete(); model_drops = 0;
    exp_p_hdr.delete(); exp_p_dat.delete(); got_p_hdr.delete(); got_p_dat.delete();
    p_dat_rdy = 1'b1;
    cycles(5);
    do_pps(cur_sec + 32'd1, 1'b0, '0, '0);
    cycles(30);
    check64("post-reset drops", {p_drops, i_drops}, 64'h0);
    check_all("post-reset silence");

    send_req(32'h01020304, 16'h0506);
    cycles(10);
    do_pps(32'h0000_0900, 1'b0, '0, '0);
    check_all("first after reset");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
`default_nettype wire
